// File: rtl/tri_point_feeder_if.sv
// Stream bundle for tri_point_feeder: vertex/point input, sign-unit bus, verdict output.
// master is the feeder side, slave is the surrounding environment.
interface tri_point_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_x;
    logic [10:0] in_y;
    logic        in_last;
    logic        so_r;
    logic        so_re;
    logic [10:0] so_x;
    logic [10:0] so_y;
    logic        si_s;
    logic        out_valid;
    logic        out_ready;
    logic        out_inside;

    modport master (
        input  in_valid, in_x, in_y, in_last, si_s, out_ready,
        output in_ready, so_r, so_re, so_x, so_y, out_valid, out_inside
    );

    modport slave (
        output in_valid, in_x, in_y, in_last, si_s, out_ready,
        input  in_ready, so_r, so_re, so_x, so_y, out_valid, out_inside
    );
endinterface

// File: rtl/tri_point_feeder.sv
// Feeds triangle vertices and test points to the pipelined edge-sign unit and
// turns each point's three latency-aligned sign bits into one inside/outside verdict.
module tri_point_feeder #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                r,
    tri_point_feeder_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        LOADV, SRST, SV0, SV1, SV2, RUN, H1, H2, DRAIN
    } state_t;

    state_t         state, state_nxt;
    logic [10:0]    vx [3];
    logic [10:0]    vy [3];
    logic [1:0]     vcnt;
    logic           pt_last;
    logic [10:0]    hold_x, hold_y;
    logic [LAT+1:0] start_pipe;
    logic           b0, b1;
    logic [CW-1:0]  in_flight, count;
    logic           fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           last_out;
    logic           start, push, pop, verdict, credit_ok, accept;

    // The third sign bit is taken straight off si_s in the push cycle.
    assign push      = start_pipe[LAT+1];
    assign verdict   = (b0 & b1 & bus.si_s) | ~(b0 | b1 | bus.si_s);
    assign credit_ok = ((CW+1)'(in_flight) + (CW+1)'(count)) < (CW+1)'(DEPTH);
    assign accept    = bus.in_valid & bus.in_ready;

    assign bus.out_valid  = ~r & (count != '0);
    assign pop            = bus.out_valid & bus.out_ready;
    assign bus.out_inside = r ? 1'b0 : ((count != '0) ? fifo_mem[rd_ptr] : last_out);

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.so_r     = 1'b0;
        bus.so_re    = 1'b0;
        bus.so_x     = hold_x;
        bus.so_y     = hold_y;
        start        = 1'b0;
        case (state)
            LOADV: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && vcnt == 2'd2) state_nxt = SRST;
            end
            SRST: begin
                bus.so_r  = 1'b1;
                state_nxt = SV0;
            end
            SV0: begin
                bus.so_x  = vx[0];
                bus.so_y  = vy[0];
                state_nxt = SV1;
            end
            SV1: begin
                bus.so_x  = vx[1];
                bus.so_y  = vy[1];
                state_nxt = SV2;
            end
            SV2: begin
                bus.so_x  = vx[2];
                bus.so_y  = vy[2];
                state_nxt = RUN;
            end
            RUN: begin
                bus.in_ready = credit_ok;
                if (bus.in_valid && credit_ok) begin
                    bus.so_re = 1'b1;
                    bus.so_x  = bus.in_x;
                    bus.so_y  = bus.in_y;
                    start     = 1'b1;
                    state_nxt = H1;
                end
            end
            H1:      state_nxt = H2;
            H2:      state_nxt = pt_last ? DRAIN : RUN;
            DRAIN:   if (in_flight == '0) state_nxt = LOADV;
            default: state_nxt = LOADV;
        endcase
        // Reset overrides every output in the same cycle it is seen.
        if (r) begin
            state_nxt    = LOADV;
            bus.in_ready = 1'b0;
            bus.so_r     = 1'b1;
            bus.so_re    = 1'b0;
            bus.so_x     = '0;
            bus.so_y     = '0;
            start        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state      <= LOADV;
            vcnt       <= '0;
            pt_last    <= 1'b0;
            hold_x     <= '0;
            hold_y     <= '0;
            start_pipe <= '0;
            b0         <= 1'b0;
            b1         <= 1'b0;
            in_flight  <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_out   <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_x     <= bus.so_x;
            hold_y     <= bus.so_y;
            start_pipe <= {start_pipe[LAT:0], start};

            if (state == LOADV && accept) begin
                vx[vcnt] <= bus.in_x;
                vy[vcnt] <= bus.in_y;
                vcnt     <= (vcnt == 2'd2) ? 2'd0 : vcnt + 2'd1;
            end
            if (start) pt_last <= bus.in_last;

            if (start_pipe[LAT-1]) b0 <= bus.si_s;
            if (start_pipe[LAT])   b1 <= bus.si_s;

            // A point holds its credit from acceptance until its verdict lands in the FIFO.
            case ({start, push})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase

            if (push) begin
                fifo_mem[wr_ptr] <= verdict;
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (count != '0) last_out <= fifo_mem[rd_ptr];
        end
    end
endmodule
